// File: rtl/psram_arb.sv
// Two-requester PSRAM arbiter: high-priority cart reads, low-priority PI read/write, burst-limited.
// Optional read preemption of PI reads by a new cart request when ARB_PREEMPT_EN is defined.
module psram_arb #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 16,
    parameter int ACC_CYC  = 4,
    parameter int REC_CYC  = 1,
    parameter int MAX_CART = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cart_req,
    input  logic [ADDR_W-1:0] i_cart_addr,
    output logic              o_cart_ack,
    output logic [DATA_W-1:0] o_cart_dat,
    input  logic              i_pi_req,
    input  logic              i_pi_we,
    input  logic [ADDR_W-1:0] i_pi_addr,
    input  logic [DATA_W-1:0] i_pi_dwr,
    output logic              o_pi_ack,
    output logic [DATA_W-1:0] o_pi_drd,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_dout,
    input  logic [DATA_W-1:0] i_mem_din,
    output logic              o_mem_ce,
    output logic              o_mem_oe,
    output logic              o_mem_we,
    output logic              o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_CART, ST_PI, ST_RECOV} state_t;

    localparam logic [3:0] ACC_LD    = 4'(ACC_CYC - 1);
    localparam logic [3:0] REC_LD    = 4'(REC_CYC - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_CART);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          r_burst;
    logic                r_src_pi;
    logic                r_cart_ack, r_pi_ack;
    logic [DATA_W-1:0]   r_cart_dat, r_pi_drd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_dout;
    logic                r_mem_ce, r_mem_oe, r_mem_we;
    logic                w_grant_cart, w_grant_pi, w_abort;
`ifdef ARB_PREEMPT_EN
    logic                r_cart_req_d;
    logic                r_preempted;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_cart = 1'b0;
        w_grant_pi   = 1'b0;
        w_abort      = 1'b0;
`ifdef ARB_PREEMPT_EN
        // Only a fresh cart request may interrupt, and only one PI read per request.
        w_abort = (r_state == ST_PI) && r_mem_oe && !r_preempted && i_cart_req && !r_cart_req_d;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_cart_req && (!i_pi_req || r_burst < BURST_MAX)) begin
                    w_grant_cart = 1'b1;
                    w_state_nxt  = ST_CART;
                end else if (i_pi_req) begin
                    w_grant_pi  = 1'b1;
                    w_state_nxt = ST_PI;
                end
            end
            ST_CART: if (r_cnt == 4'd0) w_state_nxt = ST_RECOV;
            ST_PI:   if (w_abort || r_cnt == 4'd0) w_state_nxt = ST_RECOV;
            ST_RECOV: if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_burst    <= '0;
            r_src_pi   <= 1'b0;
            r_cart_ack <= 1'b0;
            r_pi_ack   <= 1'b0;
            r_cart_dat <= '0;
            r_pi_drd   <= '0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
            r_mem_ce   <= 1'b0;
            r_mem_oe   <= 1'b0;
            r_mem_we   <= 1'b0;
`ifdef ARB_PREEMPT_EN
            r_cart_req_d <= 1'b0;
            r_preempted  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cart_ack <= 1'b0;
            r_pi_ack   <= 1'b0;
`ifdef ARB_PREEMPT_EN
            r_cart_req_d <= i_cart_req;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_cart || w_grant_pi) begin
                        r_src_pi   <= w_grant_pi;
                        r_mem_addr <= w_grant_pi ? i_pi_addr : i_cart_addr;
                        r_mem_ce   <= 1'b1;
                        r_mem_oe   <= w_grant_cart || !i_pi_we;
                        r_mem_we   <= w_grant_pi && i_pi_we;
                        r_cnt      <= ACC_LD;
                    end
                    if (w_grant_pi) r_mem_dout <= i_pi_dwr;
                    if (w_grant_pi || !i_pi_req)
                        r_burst <= '0;
                    else if (w_grant_cart && r_burst < BURST_MAX)
                        r_burst <= r_burst + 4'd1;
`ifdef ARB_PREEMPT_EN
                    if (!i_pi_req) r_preempted <= 1'b0;
`endif
                end
                ST_CART, ST_PI: begin
                    if (w_state_nxt == ST_RECOV) begin
                        r_mem_ce <= 1'b0;
                        r_mem_oe <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_cnt    <= REC_LD;
                        // Last access clock: read data is valid on the bus now.
                        if (!w_abort) begin
                            if (r_src_pi) begin
                                r_pi_ack <= 1'b1;
                                if (!r_mem_we) r_pi_drd <= i_mem_din;
                            end else begin
                                r_cart_ack <= 1'b1;
                                r_cart_dat <= i_mem_din;
                            end
                        end
`ifdef ARB_PREEMPT_EN
                        if (r_src_pi) r_preempted <= w_abort;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RECOV: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    assign o_cart_ack = r_cart_ack;
    assign o_cart_dat = r_cart_dat;
    assign o_pi_ack   = r_pi_ack;
    assign o_pi_drd   = r_pi_drd;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_dout = r_mem_dout;
    assign o_mem_ce   = r_mem_ce;
    assign o_mem_oe   = r_mem_oe;
    assign o_mem_we   = r_mem_we;
    assign o_busy     = (r_state != ST_IDLE);

endmodule
